// File: rtl/lzss_pkg.sv
// ---------------------------------------------------------------------------
// lzss_pkg
// Shared definitions for the LZSS memory clear controller:
//   - clear sequencer state encoding
//   - memory index constants (bit positions in mask / write-enable vectors)
//   - default memory geometry
//   - helper that picks the next memory to clear from a mask
// ---------------------------------------------------------------------------
package lzss_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLR_LL   = 3'd1,
        ST_CLR_DIST = 3'd2,
        ST_CLR_OUT  = 3'd3,
        ST_DONE     = 3'd4
    } clr_state_e;

    localparam logic [1:0] MEM_LL   = 2'd0;
    localparam logic [1:0] MEM_DIST = 2'd1;
    localparam logic [1:0] MEM_OUT  = 2'd2;
    localparam logic [1:0] MEM_NONE = 2'd3;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LL_DEPTH   = 286;
    localparam int DEF_DIST_DEPTH = 30;
    localparam int DEF_OUT_DEPTH  = 1024;

    // First enabled clear state at or after memory index from_idx, in the
    // fixed order LL, DIST, OUT. Disabled memories are skipped entirely so
    // they cost no cycles; nothing left means the run is finished.
    function automatic clr_state_e first_enabled(input logic [2:0] mask,
                                                 input logic [1:0] from_idx);
        logic [2:0] window;
        window = mask & (3'b111 << from_idx);
        if (window[0]) begin
            return ST_CLR_LL;
        end else if (window[1]) begin
            return ST_CLR_DIST;
        end else if (window[2]) begin
            return ST_CLR_OUT;
        end else begin
            return ST_DONE;
        end
    endfunction

endpackage

// File: rtl/lzss_clear_mux.sv
// ---------------------------------------------------------------------------
// lzss_clear_mux
// Combinational arbitration of the single shared memory write port.
// While the clear engine is active it owns the port and writes zeros;
// otherwise the client interface is passed straight through, with the
// client select decoded into a one-hot enable (select 3 drops the write).
//
// Ports:
//   i_clr_active    clear engine owns the port this cycle
//   i_clr_we        one-hot enable of the memory being cleared
//   i_clr_addr      clear address
//   i_client_we     client write strobe
//   i_client_sel    client target memory (0 ll, 1 dist, 2 out, 3 none)
//   i_client_addr   client address
//   i_client_wdata  client data
//   o_mem_we        per-memory write enables
//   o_mem_addr      shared write address
//   o_mem_wdata     shared write data
// ---------------------------------------------------------------------------
module lzss_clear_mux
    import lzss_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clr_active,
    input  logic [2:0]        i_clr_we,
    input  logic [ADDR_W-1:0] i_clr_addr,
    input  logic              i_client_we,
    input  logic [1:0]        i_client_sel,
    input  logic [ADDR_W-1:0] i_client_addr,
    input  logic [DATA_W-1:0] i_client_wdata,
    output logic [2:0]        o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata
);

    // Write-port source selection: clear engine has absolute priority, so
    // client writes issued during a clear never reach a memory.
    always_comb begin
        o_mem_we    = 3'b000;
        o_mem_addr  = {ADDR_W{1'b0}};
        o_mem_wdata = {DATA_W{1'b0}};
        if (i_clr_active) begin
            o_mem_we    = i_clr_we;
            o_mem_addr  = i_clr_addr;
            o_mem_wdata = {DATA_W{1'b0}};
        end else begin
            o_mem_addr  = i_client_addr;
            o_mem_wdata = i_client_wdata;
            case (i_client_sel)
                MEM_LL:   o_mem_we = {2'b00, i_client_we};
                MEM_DIST: o_mem_we = {1'b0, i_client_we, 1'b0};
                MEM_OUT:  o_mem_we = {i_client_we, 2'b00};
                default:  o_mem_we = 3'b000;
            endcase
        end
    end

endmodule

// File: rtl/lzss_mem_clear_ctrl.sv
// ---------------------------------------------------------------------------
// lzss_mem_clear_ctrl
// Zero-initialises the LZSS working memories (ll symbols, distance symbols,
// LZSS output) through their shared write port, using a start/busy/done
// handshake. The datapath (client) uses the same port whenever no clear is
// in progress; its writes are dropped while client_ready is low.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          clear request, honoured only in IDLE
//   clear_mask     memories to clear (bit0 ll, bit1 dist, bit2 out)
//   clear_cap      words per memory, 0 = full depth (latched with start)
//   busy           high while clear writes are issued
//   done           one-cycle completion pulse
//   client_we/sel/addr/wdata  datapath write request
//   client_ready   high when client writes take effect (IDLE/DONE)
//   mem_we/addr/wdata         shared memory write port
// ---------------------------------------------------------------------------
module lzss_mem_clear_ctrl
    import lzss_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LL_DEPTH   = DEF_LL_DEPTH,
    parameter int DIST_DEPTH = DEF_DIST_DEPTH,
    parameter int OUT_DEPTH  = DEF_OUT_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        clear_mask,
    input  logic [ADDR_W:0]   clear_cap,
    output logic              busy,
    output logic              done,
    input  logic              client_we,
    input  logic [1:0]        client_sel,
    input  logic [ADDR_W-1:0] client_addr,
    input  logic [DATA_W-1:0] client_wdata,
    output logic              client_ready,
    output logic [2:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);

    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LL_N     = CNT_W'(LL_DEPTH);
    localparam logic [CNT_W-1:0] DIST_N   = CNT_W'(DIST_DEPTH);
    localparam logic [CNT_W-1:0] OUT_N    = CNT_W'(OUT_DEPTH);

    // Words to clear in one memory: a zero or oversized cap means the
    // whole memory.
    function automatic logic [CNT_W-1:0] words_for(input logic [CNT_W-1:0] cap,
                                                   input logic [CNT_W-1:0] depth);
        if ((cap == CNT_ZERO) || (cap > depth)) begin
            return depth;
        end else begin
            return cap;
        end
    endfunction

    clr_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_mask;
    logic [CNT_W-1:0]   r_cap;
    logic               r_busy;
    logic               r_done;
    logic               r_ready;

    clr_state_e         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [2:0]         w_mask_nxt;
    logic [CNT_W-1:0]   w_cap_nxt;
    logic               w_clr_active;
    logic [2:0]         w_clr_we;
    logic [CNT_W-1:0]   w_n_ll;
    logic [CNT_W-1:0]   w_n_dist;
    logic [CNT_W-1:0]   w_n_out;

    assign w_n_ll   = words_for(r_cap, LL_N);
    assign w_n_dist = words_for(r_cap, DIST_N);
    assign w_n_out  = words_for(r_cap, OUT_N);

    // Next-state, counter and clear-engine port control.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_mask_nxt   = r_mask;
        w_cap_nxt    = r_cap;
        w_clr_active = 1'b0;
        w_clr_we     = 3'b000;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_mask_nxt  = clear_mask;
                    w_cap_nxt   = clear_cap;
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = first_enabled(clear_mask, MEM_LL);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLR_LL: begin
                w_clr_active = 1'b1;
                w_clr_we     = 3'b001;
                if (r_cnt == (w_n_ll - CNT_ONE)) begin
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = first_enabled(r_mask, MEM_DIST);
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            ST_CLR_DIST: begin
                w_clr_active = 1'b1;
                w_clr_we     = 3'b010;
                if (r_cnt == (w_n_dist - CNT_ONE)) begin
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = first_enabled(r_mask, MEM_OUT);
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            ST_CLR_OUT: begin
                w_clr_active = 1'b1;
                w_clr_we     = 3'b100;
                if (r_cnt == (w_n_out - CNT_ONE)) begin
                    w_cnt_nxt   = CNT_ZERO;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, latched request and status flags. Status flags are
    // registered from the next state so they line up with the state they
    // describe without decode glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
            r_mask  <= 3'b000;
            r_cap   <= CNT_ZERO;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mask  <= w_mask_nxt;
            r_cap   <= w_cap_nxt;
            r_busy  <= (w_state_nxt == ST_CLR_LL) || (w_state_nxt == ST_CLR_DIST) ||
                       (w_state_nxt == ST_CLR_OUT);
            r_done  <= (w_state_nxt == ST_DONE);
            r_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE);
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign client_ready = r_ready;

    lzss_clear_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .i_clr_active   (w_clr_active),
        .i_clr_we       (w_clr_we),
        .i_clr_addr     (r_cnt[ADDR_W-1:0]),
        .i_client_we    (client_we),
        .i_client_sel   (client_sel),
        .i_client_addr  (client_addr),
        .i_client_wdata (client_wdata),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata)
    );

endmodule

// File: tb/tb_lzss_mem_clear_ctrl.sv
// Self-checking bench for lzss_mem_clear_ctrl. Expected write sequences are
// built as queues of (memory, address) pairs from the mask/cap rules; the
// client path is modelled as a one-hot decode of the client request.
module tb_lzss_mem_clear_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  clear_mask;
    logic [10:0] clear_cap;
    logic        busy;
    logic        done;
    logic        client_we;
    logic [1:0]  client_sel;
    logic [9:0]  client_addr;
    logic [31:0] client_wdata;
    logic        client_ready;
    logic [2:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;

    int checks   = 0;
    int failures = 0;
    bit fixed_client = 1'b0;
    int depth [3] = '{286, 30, 1024};

    lzss_mem_clear_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .clear_mask   (clear_mask),
        .clear_cap    (clear_cap),
        .busy         (busy),
        .done         (done),
        .client_we    (client_we),
        .client_sel   (client_sel),
        .client_addr  (client_addr),
        .client_wdata (client_wdata),
        .client_ready (client_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata)
    );

    always #5 clk = ~clk;

    // Observed vector: {mem_we, mem_addr, mem_wdata, busy, done, client_ready}
    function automatic logic [47:0] obs_vec();
        return {mem_we, mem_addr, mem_wdata, busy, done, client_ready};
    endfunction

    // Expected vector when the client owns the port (IDLE or DONE).
    function automatic logic [47:0] exp_open(input logic exp_done);
        logic [2:0] we;
        if (!client_we || client_sel == 2'd3) we = 3'b000;
        else we = 3'b001 << client_sel;
        return {we, client_addr, client_wdata, 1'b0, exp_done, 1'b1};
    endfunction

    task automatic rand_client();
        if (fixed_client) begin
            client_we    = 1'b1;
            client_sel   = 2'd2;
            client_addr  = 10'd5;
            client_wdata = 32'hDEADBEEF;
        end else begin
            client_we    = 1'($urandom_range(0, 1));
            client_sel   = 2'($urandom_range(0, 3));
            client_addr  = 10'($urandom_range(0, 1023));
            client_wdata = $urandom;
        end
    endtask

    // One clear run: start at T, expected writes T+1.., done pulse, idle.
    task automatic clear_scenario(input logic [2:0] mask, input logic [10:0] cap,
                                  input int restart_at, input bit start_in_done,
                                  input string name);
        int q_mem[$];
        int q_adr[$];
        int n;
        logic [47:0] e;
        for (int m = 0; m < 3; m++) begin
            if (mask[m]) begin
                n = (cap == 11'd0 || int'(cap) > depth[m]) ? depth[m] : int'(cap);
                for (int a = 0; a < n; a++) begin
                    q_mem.push_back(m);
                    q_adr.push_back(a);
                end
            end
        end
        @(negedge clk);
        start = 1'b1; clear_mask = mask; clear_cap = cap;
        rand_client();
        #1;
        e = exp_open(1'b0);
        checks++;
        if (obs_vec() !== e) begin
            failures++;
            $display("FAIL %s start_cycle: got %h expected %h", name, obs_vec(), e);
        end
        for (int k = 1; k <= q_mem.size(); k++) begin
            @(negedge clk);
            start      = (k == restart_at);
            clear_mask = 3'($urandom);
            clear_cap  = 11'($urandom);
            rand_client();
            #1;
            e = {3'b001 << q_mem[k-1], 10'(q_adr[k-1]), 32'h0, 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs_vec() !== e) begin
                failures++;
                $display("FAIL %s clear_cycle %0d: got %h expected %h", name, k, obs_vec(), e);
            end
        end
        @(negedge clk);
        start = start_in_done; clear_mask = 3'b111; clear_cap = 11'd1;
        rand_client();
        #1;
        e = exp_open(1'b1);
        checks++;
        if (obs_vec() !== e) begin
            failures++;
            $display("FAIL %s done_cycle: got %h expected %h", name, obs_vec(), e);
        end
        @(negedge clk);
        start = 1'b0;
        rand_client();
        #1;
        e = exp_open(1'b0);
        checks++;
        if (obs_vec() !== e) begin
            failures++;
            $display("FAIL %s after_done: got %h expected %h", name, obs_vec(), e);
        end
    endtask

    task automatic test_reset();
        logic [47:0] e;
        reset = 1'b1; start = 1'b0; clear_mask = 3'b000; clear_cap = 11'd0;
        client_we = 1'b0; client_sel = 2'd0; client_addr = 10'd0; client_wdata = 32'd0;
        repeat (2) @(negedge clk);
        client_addr = 10'd17; client_wdata = 32'h1234_5678;
        #1;
        e = exp_open(1'b0);
        checks++;
        if (obs_vec() !== e) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), e);
        end
        @(negedge clk);
        reset = 1'b0;
        client_we = 1'b1; client_sel = 2'd1;
        #1;
        e = exp_open(1'b0);
        checks++;
        if (obs_vec() !== e) begin
            failures++;
            $display("FAIL reset_passthru: got %h expected %h", obs_vec(), e);
        end
    endtask

    task automatic test_cap4_all();
        clear_scenario(3'b111, 11'd4, 0, 1'b0, "cap4_all");
    endtask

    task automatic test_full_clear();
        clear_scenario(3'b111, 11'd0, 0, 1'b0, "full_clear");
    endtask

    task automatic test_dist_clamp();
        clear_scenario(3'b010, 11'd100, 0, 1'b0, "dist_clamp");
    endtask

    task automatic test_client_block();
        fixed_client = 1'b1;
        clear_scenario(3'b111, 11'd2, 0, 1'b0, "client_block");
        fixed_client = 1'b0;
    endtask

    task automatic test_restart_ignored();
        clear_scenario(3'b111, 11'd4, 2, 1'b1, "restart_ignored");
    endtask

    task automatic test_reset_mid();
        logic [47:0] e;
        @(negedge clk);
        start = 1'b1; clear_mask = 3'b111; clear_cap = 11'd0; client_we = 1'b0;
        #1;
        e = exp_open(1'b0);
        checks++;
        if (obs_vec() !== e) begin
            failures++;
            $display("FAIL reset_mid start: got %h expected %h", obs_vec(), e);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            reset = (k == 3);
            rand_client();
            #1;
            e = {3'b001, 10'(k - 1), 32'h0, 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs_vec() !== e) begin
                failures++;
                $display("FAIL reset_mid clear %0d: got %h expected %h", k, obs_vec(), e);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            reset = 1'b0;
            rand_client();
            #1;
            e = exp_open(1'b0);
            checks++;
            if (obs_vec() !== e) begin
                failures++;
                $display("FAIL reset_mid idle %0d: got %h expected %h", k, obs_vec(), e);
            end
        end
        @(negedge clk);
        start = 1'b1; clear_mask = 3'b000; clear_cap = 11'd7; client_we = 1'b0;
        #1;
        e = exp_open(1'b0);
        checks++;
        if (obs_vec() !== e) begin
            failures++;
            $display("FAIL mask0 start: got %h expected %h", obs_vec(), e);
        end
        @(negedge clk);
        start = 1'b0; client_we = 1'b0;
        #1;
        e = exp_open(1'b1);
        checks++;
        if (obs_vec() !== e || mem_we !== 3'b000) begin
            failures++;
            $display("FAIL mask0 done: got %h expected %h", obs_vec(), e);
        end
        @(negedge clk);
        rand_client();
        #1;
        e = exp_open(1'b0);
        checks++;
        if (obs_vec() !== e) begin
            failures++;
            $display("FAIL mask0 after: got %h expected %h", obs_vec(), e);
        end
    endtask

    task automatic test_random();
        logic [2:0]  m;
        logic [10:0] c;
        for (int i = 0; i < 10; i++) begin
            m = 3'($urandom);
            c = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047))
                                            : 11'($urandom_range(0, 40));
            if (m[2] && (c == 11'd0 || c > 11'd200)) c = 11'd33;
            clear_scenario(m, c, int'($urandom_range(0, 6)),
                           bit'($urandom_range(0, 1)), "random");
            repeat (int'($urandom_range(0, 2))) begin
                @(negedge clk);
                start = 1'b0;
                rand_client();
                #1;
                checks++;
                if (obs_vec() !== exp_open(1'b0)) begin
                    failures++;
                    $display("FAIL random idle: got %h expected %h", obs_vec(), exp_open(1'b0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cap4_all();
        test_full_clear();
        test_dist_clamp();
        test_client_block();
        test_restart_ignored();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
